// File: rtl/sector_scheduler.sv
// ---------------------------------------------------------------------------
// sector_scheduler
//
// Sequences disk-side transfers against the rotating sector timer. A command
// (start sector, sector count, read/write) is accepted while idle. For each
// sector, the scheduler waits for that sector to pass under the head. At
// GAP_CYCLES into the sector it opens the read or write gate. It closes the
// gate when the timer moves to the next sector, and then either advances to
// the next sector (wrapping at num_sectors) or reports completion.
//
// Parameters:
//   GAP_CYCLES    cycle_count value within a sector at which the gate opens
//   TIMEOUT_REVS  index rising edges tolerated while seeking a sector (1..15)
//
// Optional feature (macro SECTOR_SCHED_ABORT_EN):
//   adds input 'abort'; while seeking or transferring it drops both gates on
//   the next edge and completes with status 11. Without the macro there is
//   no abort port and status 11 is never produced.
//
// Ports:
//   csr_aclk, csr_areset          clock (shared with timer), async active-high reset
//   cycle_count, sector_number    live timer position
//   esdi_index                    index pulse from the timer
//   num_sectors                   sectors per track
//   cmd_valid/cmd_ready           command handshake
//   cmd_sector/cmd_count/cmd_write command fields
//   read_gate, write_gate         ESDI gates (registered, mutually exclusive)
//   xfer_start                    one-cycle pulse as each sector's gate opens
//   xfer_sector                   sector currently targeted
//   done_valid/done_ready         completion handshake
//   done_status                   00 ok, 01 timeout, 10 bad parameter, 11 aborted
// ---------------------------------------------------------------------------
module sector_scheduler #(
  parameter int unsigned GAP_CYCLES   = 1000,
  parameter int unsigned TIMEOUT_REVS = 3
) (
  input  logic        csr_aclk,
  input  logic        csr_areset,
  input  logic [31:0] cycle_count,
  input  logic [7:0]  sector_number,
  input  logic        esdi_index,
  input  logic [7:0]  num_sectors,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_sector,
  input  logic [7:0]  cmd_count,
  input  logic        cmd_write,
  output logic        read_gate,
  output logic        write_gate,
  output logic        xfer_start,
  output logic [7:0]  xfer_sector,
  output logic        done_valid,
  input  logic        done_ready,
`ifdef SECTOR_SCHED_ABORT_EN
  input  logic        abort,
`endif
  output logic [1:0]  done_status
);

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_XFER, S_DONE} state_t;

  localparam logic [1:0]  ST_OK       = 2'b00;
  localparam logic [1:0]  ST_TIMEOUT  = 2'b01;
  localparam logic [1:0]  ST_BADPARAM = 2'b10;
  localparam logic [1:0]  ST_ABORT    = 2'b11;
  localparam logic [31:0] GAP         = 32'(GAP_CYCLES);
  localparam logic [3:0]  TIMEOUT     = 4'(TIMEOUT_REVS);

  state_t     state;
  logic [7:0] cur;
  logic [7:0] remaining;
  logic [3:0] rev_cnt;
  logic       index_p1;
  logic       wr_sel;
  logic       accept;
  logic       gap_hit;
  logic       index_rise;
  logic       sector_left;
  logic       abort_req;

  // Next sector in track order; num_sectors is sampled live.
  function automatic logic [7:0] next_sector(input logic [7:0] s, input logic [7:0] n);
    return (s == n - 8'd1) ? 8'd0 : s + 8'd1;
  endfunction

  // cmd_ready is forced low while reset is held, not just after it.
  assign cmd_ready   = (state == S_IDLE) && !done_valid && !csr_areset;
  assign accept      = cmd_valid && cmd_ready;
  assign gap_hit     = (sector_number == cur) && (cycle_count == GAP);
  assign index_rise  = esdi_index && !index_p1;
  assign sector_left = (sector_number != cur);
  assign xfer_sector = cur;

`ifdef SECTOR_SCHED_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Direction is data, not control: latched on accept, never reset.
  always_ff @(posedge csr_aclk) begin
    if (accept) wr_sel <= cmd_write;
  end

  always_ff @(posedge csr_aclk or posedge csr_areset) begin
    if (csr_areset) begin
      state       <= S_IDLE;
      cur         <= 8'd0;
      remaining   <= 8'd0;
      rev_cnt     <= 4'd0;
      index_p1    <= 1'b0;
      read_gate   <= 1'b0;
      write_gate  <= 1'b0;
      xfer_start  <= 1'b0;
      done_valid  <= 1'b0;
      done_status <= ST_OK;
    end else begin
      index_p1   <= esdi_index;
      xfer_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (cmd_count == 8'd0 || cmd_sector >= num_sectors) begin
              state       <= S_DONE;
              done_valid  <= 1'b1;
              done_status <= ST_BADPARAM;
            end else begin
              cur       <= cmd_sector;
              remaining <= cmd_count;
              rev_cnt   <= 4'd0;
              state     <= S_SEEK;
            end
          end
        end
        S_SEEK: begin
          if (abort_req) begin
            state       <= S_DONE;
            done_valid  <= 1'b1;
            done_status <= ST_ABORT;
          end else if (gap_hit) begin
            state      <= S_XFER;
            read_gate  <= !wr_sel;
            write_gate <= wr_sel;
            xfer_start <= 1'b1;
          end else if (index_rise) begin
            // A full revolution without the target sector counts one strike.
            if (rev_cnt + 4'd1 == TIMEOUT) begin
              state       <= S_DONE;
              done_valid  <= 1'b1;
              done_status <= ST_TIMEOUT;
            end
            rev_cnt <= rev_cnt + 4'd1;
          end
        end
        S_XFER: begin
          if (abort_req) begin
            read_gate   <= 1'b0;
            write_gate  <= 1'b0;
            state       <= S_DONE;
            done_valid  <= 1'b1;
            done_status <= ST_ABORT;
          end else if (sector_left) begin
            read_gate  <= 1'b0;
            write_gate <= 1'b0;
            remaining  <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state       <= S_DONE;
              done_valid  <= 1'b1;
              done_status <= ST_OK;
            end else begin
              cur     <= next_sector(cur, num_sectors);
              rev_cnt <= 4'd0;
              state   <= S_SEEK;
            end
          end
        end
        S_DONE: begin
          if (done_ready) begin
            state      <= S_IDLE;
            done_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sector_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sector_scheduler
//
// Bench for sector_scheduler. A free-running timer model produces
// sector_number / cycle_count / esdi_index; it can be frozen, and index
// pulses can then be injected by hand. A behavioural model keeps the list of
// sectors still to visit, plus whether a gate is open and whether a
// completion is pending. Every cycle, all DUT outputs are compared with the
// model. Directed scenarios add literal expectations, and a randomized phase
// follows them.
// ---------------------------------------------------------------------------
module tb_sector_scheduler;

  localparam int GAP    = 10;
  localparam int SECLEN = 25;
  localparam int TSECT  = 8;
  localparam int TOREVS = 3;

  logic        csr_aclk = 1'b0;
  logic        csr_areset = 1'b1;
  logic [31:0] cycle_count = '0;
  logic [7:0]  sector_number = '0;
  logic        esdi_index = 1'b0;
  logic [7:0]  num_sectors = 8'd8;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_sector = '0;
  logic [7:0]  cmd_count = '0;
  logic        cmd_write = 1'b0;
  logic        read_gate;
  logic        write_gate;
  logic        xfer_start;
  logic [7:0]  xfer_sector;
  logic        done_valid;
  logic        done_ready = 1'b1;
  logic [1:0]  done_status;
`ifdef SECTOR_SCHED_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit freeze = 1'b0;
  bit inj_index = 1'b0;

  sector_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_REVS(TOREVS)) dut (
    .csr_aclk(csr_aclk), .csr_areset(csr_areset),
    .cycle_count(cycle_count), .sector_number(sector_number), .esdi_index(esdi_index),
    .num_sectors(num_sectors),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sector(cmd_sector), .cmd_count(cmd_count), .cmd_write(cmd_write),
    .read_gate(read_gate), .write_gate(write_gate),
    .xfer_start(xfer_start), .xfer_sector(xfer_sector),
    .done_valid(done_valid), .done_ready(done_ready),
`ifdef SECTOR_SCHED_ABORT_EN
    .abort(abort),
`endif
    .done_status(done_status)
  );

  always #5 csr_aclk = ~csr_aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Rotating sector timer; index is high for the first two cycles of sector 0.
  initial begin
    forever begin
      @(negedge csr_aclk);
      if (freeze) begin
        esdi_index = inj_index;
      end else begin
        if (cycle_count == 32'(SECLEN - 1)) begin
          cycle_count   = '0;
          sector_number = (sector_number == 8'(TSECT - 1)) ? 8'd0 : sector_number + 8'd1;
        end else begin
          cycle_count = cycle_count + 32'd1;
        end
        esdi_index = (sector_number == 8'd0) && (cycle_count < 32'd2);
      end
    end
  end

  // ---------------- behavioural model ----------------
  // num_sectors only changes while the scheduler is idle, so the whole
  // visiting order can be laid out when the command is taken.
  logic [7:0] m_todo[$];
  bit         m_open = 1'b0;
  bit         m_done = 1'b0;
  bit         m_wr = 1'b0;
  bit         m_start = 1'b0;
  bit         m_prev_idx = 1'b0;
  logic [1:0] m_status = 2'b00;
  logic [7:0] m_sec = 8'd0;
  int         m_revs = 0;

  task automatic model_step();
    bit         rise;
    logic [7:0] s;
    if (csr_areset) begin
      m_todo.delete();
      m_open = 0; m_done = 0; m_start = 0; m_prev_idx = 0;
      m_status = 2'b00; m_sec = 8'd0; m_revs = 0;
      return;
    end
    rise       = esdi_index && !m_prev_idx;
    m_prev_idx = esdi_index;
    m_start    = 0;
    if (m_done) begin
      if (done_ready) m_done = 0;
    end else if (m_todo.size() == 0) begin
      if (cmd_valid) begin
        if (cmd_count == 8'd0 || cmd_sector >= num_sectors) begin
          m_done = 1; m_status = 2'b10;
        end else begin
          s = cmd_sector;
          for (int i = 0; i < int'(cmd_count); i++) begin
            m_todo.push_back(s);
            s = (s == num_sectors - 8'd1) ? 8'd0 : s + 8'd1;
          end
          m_wr = cmd_write; m_revs = 0; m_sec = cmd_sector;
        end
      end
    end
`ifdef SECTOR_SCHED_ABORT_EN
    else if (abort) begin
      m_todo.delete(); m_open = 0; m_done = 1; m_status = 2'b11;
    end
`endif
    else if (!m_open) begin
      if (sector_number == m_todo[0] && cycle_count == 32'(GAP)) begin
        m_open = 1; m_start = 1;
      end else if (rise) begin
        m_revs++;
        if (m_revs == TOREVS) begin
          m_todo.delete(); m_done = 1; m_status = 2'b01;
        end
      end
    end else if (sector_number != m_todo[0]) begin
      m_open = 0;
      void'(m_todo.pop_front());
      if (m_todo.size() == 0) begin
        m_done = 1; m_status = 2'b00;
      end else begin
        m_revs = 0; m_sec = m_todo[0];
      end
    end
  endtask

  // Per-cycle compare: {cmd_ready, done_valid, done_status, read_gate, write_gate, xfer_start, xfer_sector}
  initial begin
    logic [14:0] exp_v;
    forever begin
      @(posedge csr_aclk);
      model_step();
      #1;
      exp_v = {!csr_areset && (m_todo.size() == 0) && !m_done, m_done, m_status,
               m_open && !m_wr, m_open && m_wr, m_start, m_sec};
      check("cycle_outputs", 32'({cmd_ready, done_valid, done_status, read_gate, write_gate,
                                  xfer_start, xfer_sector}), 32'(exp_v));
    end
  end

  // ---------------- directed helpers ----------------
  logic [7:0]  seen_secs[$];
  bit          w_rd, w_wr, w_done;
  logic [1:0]  w_status;
  logic [7:0]  rise_sec, fall_sec;
  logic [31:0] rise_cc, fall_cc;

  task automatic issue(input logic [7:0] s, input logic [7:0] c, input logic w);
    int k;
    @(negedge csr_aclk);
    cmd_valid = 1'b1; cmd_sector = s; cmd_count = c; cmd_write = w;
    k = 0;
    while (!cmd_ready && k < 5000) begin
      @(negedge csr_aclk);
      k++;
    end
    check("issue_ready", 32'(cmd_ready), 32'd1);
    @(negedge csr_aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic watch(input int budget);
    bit prev = 1'b0;
    bit rose = 1'b0;
    bit fell = 1'b0;
    seen_secs.delete();
    w_rd = 0; w_wr = 0; w_done = 0; w_status = 2'b00;
    rise_sec = 8'hff; fall_sec = 8'hff; rise_cc = '1; fall_cc = '1;
    for (int k = 0; k < budget; k++) begin
      @(posedge csr_aclk);
      #1;
      if (xfer_start) seen_secs.push_back(xfer_sector);
      if (read_gate) w_rd = 1;
      if (write_gate) w_wr = 1;
      if ((read_gate || write_gate) && !prev && !rose) begin
        rose = 1; rise_sec = sector_number; rise_cc = cycle_count;
      end
      if (!(read_gate || write_gate) && prev && !fell) begin
        fell = 1; fall_sec = sector_number; fall_cc = cycle_count;
      end
      prev = read_gate || write_gate;
      if (done_valid) begin
        w_done = 1; w_status = done_status;
        break;
      end
    end
  endtask

  function automatic logic [7:0] seen_at(input int i);
    return (seen_secs.size() > i) ? seen_secs[i] : 8'hff;
  endfunction

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int         k;
    logic [7:0] target;

    // Reset values
    repeat (3) @(posedge csr_aclk);
    #1;
    check("reset_outputs", 32'({read_gate, write_gate, xfer_start, xfer_sector,
                                done_valid, done_status, cmd_ready}), 32'd0);
    @(negedge csr_aclk);
    csr_areset = 1'b0;

    // Single-sector read of sector 3
    issue(8'd3, 8'd1, 1'b0);
    watch(600);
    check("t1_done", 32'(w_done), 32'd1);
    check("t1_status", 32'(w_status), 32'd0);
    check("t1_rise_sector", 32'(rise_sec), 32'd3);
    check("t1_rise_cycle", rise_cc, 32'd10);
    check("t1_fall_sector", 32'(fall_sec), 32'd4);
    check("t1_fall_cycle", fall_cc, 32'd0);
    check("t1_start_pulses", 32'(seen_secs.size()), 32'd1);
    check("t1_write_gate_idle", 32'(w_wr), 32'd0);

    // Four-sector write wrapping past the last sector
    issue(8'd6, 8'd4, 1'b1);
    watch(1500);
    check("t2_done", 32'(w_done), 32'd1);
    check("t2_status", 32'(w_status), 32'd0);
    check("t2_start_pulses", 32'(seen_secs.size()), 32'd4);
    check("t2_sec0", 32'(seen_at(0)), 32'd6);
    check("t2_sec1", 32'(seen_at(1)), 32'd7);
    check("t2_sec2", 32'(seen_at(2)), 32'd0);
    check("t2_sec3", 32'(seen_at(3)), 32'd1);
    check("t2_read_gate_idle", 32'(w_rd), 32'd0);

    // Bad parameters: zero count, then sector out of range
    issue(8'd2, 8'd0, 1'b0);
    check("t3a_done_status", 32'({done_valid, done_status, read_gate, write_gate}), 32'b11000);
    issue(8'd8, 8'd1, 1'b1);
    check("t3b_done_status", 32'({done_valid, done_status, read_gate, write_gate}), 32'b11000);

    // Timeout with frozen timer and injected index pulses
    @(posedge csr_aclk);
    #2 inj_index = 1'b0; freeze = 1'b1;
    @(negedge csr_aclk);
    target = 8'((int'(sector_number) + 4) % TSECT);
    done_ready = 1'b0;
    issue(target, 8'd1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      if (p == 2) check("t4_not_early", 32'(done_valid), 32'd0);
      @(posedge csr_aclk);
      #2 inj_index = 1'b1;
      repeat (3) @(posedge csr_aclk);
      #2 inj_index = 1'b0;
      repeat (3) @(posedge csr_aclk);
    end
    #1;
    check("t4_timeout", 32'({done_valid, done_status, read_gate, write_gate}), 32'b10100);
    @(negedge csr_aclk);
    done_ready = 1'b1;
    @(posedge csr_aclk);
    #2 freeze = 1'b0;

    // Completion held off by done_ready
    @(negedge csr_aclk);
    done_ready = 1'b0;
    issue(8'd1, 8'd0, 1'b0);
    @(negedge csr_aclk);
    cmd_valid = 1'b1; cmd_sector = 8'd2; cmd_count = 8'd1; cmd_write = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge csr_aclk);
      #1;
      check("t5_hold", 32'({done_valid, cmd_ready}), 32'b10);
    end
    @(negedge csr_aclk);
    done_ready = 1'b1;
    @(posedge csr_aclk);
    #1;
    check("t5_release", 32'({done_valid, cmd_ready}), 32'b01);
    @(posedge csr_aclk);
    #1;
    check("t5_accepted", 32'(cmd_ready), 32'd0);
    @(negedge csr_aclk);
    cmd_valid = 1'b0;
    watch(600);
    check("t5_status", 32'({w_done, w_status}), 32'b100);
    check("t5_sector", 32'(seen_at(0)), 32'd2);

    // Reset pulsed mid-transfer
    issue(8'd5, 8'd2, 1'b1);
    for (k = 0; k < 600; k++) begin
      @(posedge csr_aclk);
      #1;
      if (write_gate) break;
    end
    check("t6_gate_open", 32'(write_gate), 32'd1);
    #2 csr_areset = 1'b1;
    #1;
    check("t6_async_reset", 32'({read_gate, write_gate, xfer_start, xfer_sector,
                                 done_valid, done_status, cmd_ready}), 32'd0);
    @(posedge csr_aclk);
    @(negedge csr_aclk);
    csr_areset = 1'b0;

`ifdef SECTOR_SCHED_ABORT_EN
    // Abort mid-transfer
    issue(8'd5, 8'd2, 1'b0);
    for (k = 0; k < 600; k++) begin
      @(posedge csr_aclk);
      #1;
      if (read_gate) break;
    end
    check("t7_gate_open", 32'(read_gate), 32'd1);
    @(negedge csr_aclk);
    abort = 1'b1;
    @(posedge csr_aclk);
    #1;
    check("t7_abort", 32'({done_valid, done_status, read_gate, write_gate}), 32'b11100);
    @(negedge csr_aclk);
    abort = 1'b0;
`endif

    // Randomized commands; num_sectors=10 also exercises unreachable sectors
    for (int t = 0; t < 40; t++) begin
      @(negedge csr_aclk);
      num_sectors = ($urandom_range(0, 3) == 0) ? 8'd10 : 8'd8;
      issue(8'($urandom_range(0, 10)),
            ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4)),
            1'($urandom_range(0, 1)));
      k = 0;
      do begin
        @(negedge csr_aclk);
        done_ready = 1'($urandom_range(0, 1));
`ifdef SECTOR_SCHED_ABORT_EN
        abort = ($urandom_range(0, 199) == 0);
`endif
        k++;
      end while (!cmd_ready && k < 4000);
`ifdef SECTOR_SCHED_ABORT_EN
      abort = 1'b0;
`endif
      done_ready = 1'b1;
      check("rand_complete", 32'(cmd_ready), 32'd1);
    end

    repeat (3) @(posedge csr_aclk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sector_scheduler.md
Name: sector_scheduler

Overview:
- Sequences disk-side data transfers against the rotating sector timer.
- Accepts a command: start sector, sector count, read/write.
- Tracks the live sector_number / cycle_count from the timer and waits for the target sector to pass under the head.
- Asserts the ESDI read/write gate for each sector in turn, wrapping past the last sector, then reports completion status through a valid/ready done channel.

Parameters:
- GAP_CYCLES, 1000, cycle_count value within a sector at which the gate opens (header/sync gap after the sector pulse).
- TIMEOUT_REVS, 3, index pulses allowed while waiting for a sector before giving up (1..15).

Ports:
- csr_aclk  in  1  clock, shared with the sector timer.
- csr_areset  in  1  asynchronous, active-high reset.
- cycle_count  in  32  live cycle count within the current sector.
- sector_number  in  8  live sector under the head.
- esdi_index  in  1  index pulse from the timer.
- num_sectors  in  8  sectors per track (configured value).
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_sector  in  8  first sector.
- cmd_count  in  8  number of sectors.
- cmd_write  in  1  1 = write gate, 0 = read gate.
- read_gate  out  1  ESDI read gate.
- write_gate  out  1  ESDI write gate.
- xfer_start  out  1  one-cycle pulse as each sector's gate opens.
- xfer_sector  out  8  sector currently targeted.
- done_valid  out  1  completion pending.
- done_ready  in  1  completion consumed.
- done_status  out  2  00 ok, 01 timeout, 10 bad parameter, 11 aborted.

Behaviour:
- Reset values: all outputs 0, state IDLE, cmd_ready 0 while in reset. Reset mid-transfer drops both gates immediately (asynchronous).
- cmd_ready = (state==IDLE) && !done_valid.
- On accept: cmd_sector, cmd_count and cmd_write are latched; cur<=cmd_sector; remaining<=cmd_count; rev_cnt<=0.
- Parameter check on accept: if cmd_count==0 or cmd_sector>=num_sectors, go to DONE with status 10; no gate asserts.
- SEEK state: when sector_number==cur and cycle_count==GAP_CYCLES, go to XFER on the next edge.
  - On that same edge, the selected gate rises and xfer_start pulses for exactly one cycle.
- Timeout: rising edges of esdi_index in SEEK increment rev_cnt. When rev_cnt reaches TIMEOUT_REVS, go to DONE with status 01.
  - rev_cnt clears on every entry to SEEK.
- XFER state: the gate holds while sector_number==cur.
  - When sector_number!=cur, the gate falls on the next edge and remaining decrements.
  - If remaining was 1, go to DONE with status 00.
  - Otherwise cur<=(cur==num_sectors-1) ? 0 : cur+1, then return to SEEK.
  - Consecutive sectors therefore reopen at GAP_CYCLES of the following sector.
- Gate exclusivity: read_gate and write_gate are never both 1. Both are registered outputs.
- xfer_sector equals cur in SEEK and XFER, and holds its last value otherwise.
- DONE: done_valid=1 and done_status are held until done_ready, then return to IDLE.
  - done_valid&done_ready in the same cycle that DONE is entered completes one cycle later.
  - cmd_ready stays 0 until that completion.
- Counter arithmetic:
  - remaining is 8 bits; cmd_count up to 255 is supported.
  - Wrap-around of cur follows num_sectors, sampled live.
- No gate occurs if GAP_CYCLES is never reached within a sector (GAP_CYCLES >= sector length). The timeout covers this case.

Optional Feature:
- Macro SECTOR_SCHED_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort high in SEEK or XFER drops both gates on the next edge and goes to DONE with status 11.
  - abort in IDLE or DONE is ignored.
  - abort and the completion condition in the same cycle: abort wins.
- Undefined: no abort port; status 11 is never produced.

Test Plan:
- num_sectors=8, sector length 5000, cmd_sector=3, count=1, read: read_gate rises the cycle after sector_number==3 & cycle_count==1000. xfer_start is a single pulse. Gate falls the cycle after sector_number becomes 4. done_status=00; write_gate stays 0 throughout.
- cmd_sector=6, count=4, write, num_sectors=8: gates for sectors 6,7,0,1 in order (xfer_sector 6→7→0→1); four xfer_start pulses; status 00.
- cmd_count=0 and, separately, cmd_sector=8 with num_sectors=8: no gate; done_status=10 within 2 cycles of accept.
- Timer frozen (cycle_count never reaches GAP_CYCLES) with index pulses injected: done_status=01 after the 3rd index rising edge; gates stay 0.
- Hold done_ready low 20 cycles after completion: done_valid holds, cmd_ready=0, a new cmd_valid is not accepted. Release done_ready: IDLE next cycle, then accepted.
- csr_areset pulsed mid-XFER (plus abort mid-XFER with SECTOR_SCHED_ABORT_EN): gate drops asynchronously and all outputs go to 0 for reset. For abort, the gate drops the next edge and done_status=11.
